// File: rtl/cnn_ctrl_pkg.sv
// Shared definitions for the CNN layer sequencer: FSM states, error codes,
// status-word bit positions and the default layer-index width.
package cnn_ctrl_pkg;

  localparam int LAYER_W_DEFAULT = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_NEXT   = 3'd3,
    ST_FINISH = 3'd4
  } seq_state_e;

  localparam logic [3:0] ERR_NONE        = 4'd0;
  localparam logic [3:0] ERR_ZERO_LAYERS = 4'd1;
  localparam logic [3:0] ERR_LAYER       = 4'd2;
  localparam logic [3:0] ERR_ABORT       = 4'd3;
  localparam logic [3:0] ERR_TIMEOUT     = 4'd4;

  // status = {16'b0, err_code, 1'b0, layer_idx[7:0], busy, err, done}
  localparam int STAT_DONE_BIT = 0;
  localparam int STAT_ERR_BIT  = 1;
  localparam int STAT_BUSY_BIT = 2;
  localparam int STAT_IDX_LSB  = 3;
  localparam int STAT_IDX_W    = 8;
  localparam int STAT_CODE_LSB = 12;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Walks the datapath through csr_num_layers start/done handshakes and reports
// progress via status/cycle_count/irq. Define SEQ_WATCHDOG_EN for a per-layer timeout.
module cnn_layer_sequencer
  import cnn_ctrl_pkg::*;
#(
  parameter int LAYER_W     = LAYER_W_DEFAULT,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               csr_start,
  input  logic               csr_abort,
  input  logic               csr_irq_en,
  input  logic               csr_irq_clr,
  input  logic [LAYER_W-1:0] csr_num_layers,
  output logic               layer_start,
  output logic [LAYER_W-1:0] layer_idx,
  input  logic               layer_done,
  input  logic               layer_err,
  output logic               busy,
  output logic               done_sticky,
  output logic               err_sticky,
  output logic               irq,
  output logic [31:0]        status,
  output logic [CNT_W-1:0]   cycle_count
);

  seq_state_e         state_reg, state_next;
  logic [LAYER_W-1:0] num_layers_reg, num_layers_next;
  logic [LAYER_W-1:0] layer_idx_reg, layer_idx_next;
  logic               done_reg, done_next;
  logic               err_reg, err_next;
  logic [3:0]         err_code_reg, err_code_next;
  logic               irq_reg;
  logic               cnt_clr;
  logic               wd_timeout;

  assign busy        = (state_reg != ST_IDLE);
  assign layer_start = (state_reg == ST_LAUNCH);
  assign layer_idx   = layer_idx_reg;
  assign done_sticky = done_reg;
  assign err_sticky  = err_reg;
  assign irq         = irq_reg;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (ACLK),
    .rst   (ARESET),
    .clr   (cnt_clr),
    .en    (busy),
    .count (cycle_count)
  );

`ifdef SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
  logic [WD_W-1:0] wd_count;

  sat_counter #(.W(WD_W)) u_watchdog (
    .clk   (ACLK),
    .rst   (ARESET),
    .clr   (state_reg == ST_LAUNCH),
    .en    (state_reg == ST_WAIT),
    .count (wd_count)
  );

  assign wd_timeout = (state_reg == ST_WAIT) && (wd_count == WD_W'(TIMEOUT_CYC - 1));
`else
  // No watchdog: the term is constant false but keeps TIMEOUT_CYC referenced.
  assign wd_timeout = 1'b0 & (TIMEOUT_CYC == 0);
`endif

  always_comb begin
    state_next      = state_reg;
    num_layers_next = num_layers_reg;
    layer_idx_next  = layer_idx_reg;
    done_next       = done_reg;
    err_next        = err_reg;
    err_code_next   = err_code_reg;
    cnt_clr         = 1'b0;

    // Clear is applied first so any setting event below overrides it.
    if (csr_irq_clr) begin
      done_next = 1'b0;
      err_next  = 1'b0;
    end

    unique case (state_reg)
      ST_IDLE: begin
        if (csr_start) begin
          done_next = 1'b0;
          if (csr_num_layers != '0) begin
            state_next      = ST_LAUNCH;
            num_layers_next = csr_num_layers;
            layer_idx_next  = '0;
            err_next        = 1'b0;
            err_code_next   = ERR_NONE;
            cnt_clr         = 1'b1;
          end else begin
            err_next      = 1'b1;
            err_code_next = ERR_ZERO_LAYERS;
          end
        end
      end
      ST_LAUNCH: state_next = ST_WAIT;
      ST_WAIT: begin
        if (layer_done) begin
          if (layer_err) begin
            state_next    = ST_IDLE;
            err_next      = 1'b1;
            err_code_next = ERR_LAYER;
          end else begin
            state_next = ST_NEXT;
          end
        end else if (wd_timeout) begin
          state_next    = ST_IDLE;
          err_next      = 1'b1;
          err_code_next = ERR_TIMEOUT;
        end
      end
      ST_NEXT: begin
        if (layer_idx_reg == (num_layers_reg - LAYER_W'(1))) begin
          state_next = ST_FINISH;
        end else begin
          layer_idx_next = layer_idx_reg + LAYER_W'(1);
          state_next     = ST_LAUNCH;
        end
      end
      ST_FINISH: begin
        done_next  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Abort overrides every busy-state decision, including a same-cycle layer_done.
    if (busy && csr_abort) begin
      state_next     = ST_IDLE;
      layer_idx_next = layer_idx_reg;
      done_next      = 1'b0;
      err_next       = 1'b1;
      err_code_next  = ERR_ABORT;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg      <= ST_IDLE;
      num_layers_reg <= '0;
      layer_idx_reg  <= '0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      err_code_reg   <= ERR_NONE;
      irq_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      num_layers_reg <= num_layers_next;
      layer_idx_reg  <= layer_idx_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
      err_code_reg   <= err_code_next;
      irq_reg        <= csr_irq_en & (done_reg | err_reg);
    end
  end

  always_comb begin
    status                                   = '0;
    status[STAT_DONE_BIT]                    = done_reg;
    status[STAT_ERR_BIT]                     = err_reg;
    status[STAT_BUSY_BIT]                    = busy;
    status[STAT_IDX_LSB +: STAT_IDX_W]       = STAT_IDX_W'(layer_idx_reg);
    status[STAT_CODE_LSB +: 4]               = err_code_reg;
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer: table of complete runs against a
// latency-programmable datapath model, plus abort, reset and start-while-busy sequences.
module tb_cnn_layer_sequencer;
  import cnn_ctrl_pkg::*;

  localparam int LW = 3;
  localparam int CW = 32;
  localparam int TO = 16;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic          csr_start = 1'b0;
  logic          csr_abort = 1'b0;
  logic          csr_irq_en = 1'b1;
  logic          csr_irq_clr = 1'b0;
  logic [LW-1:0] csr_num_layers = '0;
  logic          layer_start;
  logic [LW-1:0] layer_idx;
  logic          layer_done = 1'b0;
  logic          layer_err = 1'b0;
  logic          busy;
  logic          done_sticky;
  logic          err_sticky;
  logic          irq;
  logic [31:0]   status;
  logic [CW-1:0] cycle_count;

  int n_tests = 0;
  int n_fail  = 0;

  cnn_layer_sequencer #(.LAYER_W(LW), .CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
    .ACLK           (ACLK),
    .ARESET         (ARESET),
    .csr_start      (csr_start),
    .csr_abort      (csr_abort),
    .csr_irq_en     (csr_irq_en),
    .csr_irq_clr    (csr_irq_clr),
    .csr_num_layers (csr_num_layers),
    .layer_start    (layer_start),
    .layer_idx      (layer_idx),
    .layer_done     (layer_done),
    .layer_err      (layer_err),
    .busy           (busy),
    .done_sticky    (done_sticky),
    .err_sticky     (err_sticky),
    .irq            (irq),
    .status         (status),
    .cycle_count    (cycle_count)
  );

  always #5 ACLK = ~ACLK;

  // Datapath model: answers each layer_start with layer_done resp_lat cycles later.
  int resp_lat = 5;
  int resp_err_layer = -1;
  bit resp_en = 1'b1;
  int start_cnt = 0;
  int pend = 0;
  int resp_idx = 0;

  always begin
    @(posedge ACLK);
    #1;
    layer_done = 1'b0;
    layer_err  = 1'b0;
    if (ARESET) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          layer_done = 1'b1;
          layer_err  = (resp_idx == resp_err_layer);
        end
      end
      if (layer_start) begin
        start_cnt++;
        if (resp_en) begin
          pend     = resp_lat;
          resp_idx = int'(layer_idx);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int cyc = 0;
    while (busy === 1'b1 && cyc < budget) begin
      @(negedge ACLK);
      cyc++;
    end
    if (busy !== 1'b0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL %s: still busy after %0d cycles", name, budget);
    end
  endtask

  task automatic pulse_clr();
    @(negedge ACLK);
    csr_irq_clr = 1'b1;
    @(negedge ACLK);
    csr_irq_clr = 1'b0;
  endtask

  task automatic start_run(input int n);
    csr_num_layers = LW'(n);
    csr_start = 1'b1;
    @(negedge ACLK);
    csr_start = 1'b0;
  endtask

  typedef struct {
    int n;
    int lat;
    int err_layer;
    int starts;
    bit done;
    bit err;
    int code;
    int idx;
    int cc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int s0;
    int guard;

    //          n lat errL starts done err code idx cc
    vecs[0] = '{3, 5, -1, 3, 1'b1, 1'b0, 0, 2, 22};
    vecs[1] = '{4, 5,  1, 2, 1'b0, 1'b1, 2, 1, 13};
    vecs[2] = '{1, 1, -1, 1, 1'b1, 1'b0, 0, 0,  4};
    vecs[3] = '{7, 2, -1, 7, 1'b1, 1'b0, 0, 6, 29};
    vecs[4] = '{0, 5, -1, 0, 1'b0, 1'b1, 1, 6, 29};
    vecs[5] = '{2, 3,  1, 2, 1'b0, 1'b1, 2, 1,  9};
    vecs[6] = '{5, 1,  0, 1, 1'b0, 1'b1, 2, 0,  2};

    // Reset state
    @(negedge ACLK);
    chk("rst_busy", busy, 0);
    chk("rst_status", status, 0);
    chk("rst_cc", cycle_count, 0);
    chk("rst_irq", irq, 0);
    chk("rst_start", layer_start, 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);

    for (int k = 0; k < 7; k++) begin
      resp_lat       = vecs[k].lat;
      resp_err_layer = vecs[k].err_layer;
      resp_en        = 1'b1;
      pulse_clr();
      s0 = start_cnt;
      start_run(vecs[k].n);
      wait_idle(400, $sformatf("v%0d_idle", k));
      @(negedge ACLK);
      $display("[TB] vec %0d n=%0d lat=%0d err_layer=%0d -> starts=%0d code=%0d idx=%0d cc=%0d",
               k, vecs[k].n, vecs[k].lat, vecs[k].err_layer, start_cnt - s0,
               status[15:12], layer_idx, cycle_count);
      chk($sformatf("v%0d_starts", k), start_cnt - s0, vecs[k].starts);
      chk($sformatf("v%0d_done", k), done_sticky, vecs[k].done);
      chk($sformatf("v%0d_err", k), err_sticky, vecs[k].err);
      chk($sformatf("v%0d_code", k), status[15:12], vecs[k].code);
      chk($sformatf("v%0d_idx", k), layer_idx, vecs[k].idx);
      chk($sformatf("v%0d_stidx", k), status[10:3], vecs[k].idx);
      chk($sformatf("v%0d_stlow", k), status[2:0], {1'b0, vecs[k].err, vecs[k].done});
      chk($sformatf("v%0d_cc", k), cycle_count, vecs[k].cc);
      chk($sformatf("v%0d_irq", k), irq, vecs[k].done | vecs[k].err);
    end

    // Abort coincident with layer_done in WAIT: abort wins
    resp_lat = 5;
    resp_err_layer = -1;
    pulse_clr();
    s0 = start_cnt;
    start_run(3);
    guard = 0;
    while (layer_done !== 1'b1 && guard < 50) begin
      @(negedge ACLK);
      guard++;
    end
    chk("abort_saw_done", layer_done, 1);
    csr_abort = 1'b1;
    @(negedge ACLK);
    csr_abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_code", status[15:12], 3);
    chk("abort_err", err_sticky, 1);
    chk("abort_idx", layer_idx, 0);
    repeat (10) @(negedge ACLK);
    chk("abort_starts", start_cnt - s0, 1);
    chk("abort_irq", irq, 1);
    $display("[TB] abort seq: starts=%0d code=%0d", start_cnt - s0, status[15:12]);
    csr_irq_clr = 1'b1;
    @(negedge ACLK);
    csr_irq_clr = 1'b0;
    chk("clr_err", err_sticky, 0);
    chk("clr_irq_lag", irq, 1);
    @(negedge ACLK);
    chk("clr_irq", irq, 0);
    csr_abort = 1'b1;
    @(negedge ACLK);
    csr_abort = 1'b0;
    @(negedge ACLK);
    chk("idle_abort_err", err_sticky, 0);
    chk("idle_abort_code", status[15:12], 3);

    // Reset during the second layer's launch, then a run with a start while busy
    start_run(3);
    guard = 0;
    while (!(layer_start === 1'b1 && layer_idx == 1) && guard < 60) begin
      @(negedge ACLK);
      guard++;
    end
    chk("mid_run_launch", layer_idx, 1);
    ARESET = 1'b1;
    #1;
    chk("arst_start", layer_start, 0);
    chk("arst_busy", busy, 0);
    chk("arst_status", status, 0);
    chk("arst_cc", cycle_count, 0);
    chk("arst_irq", irq, 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    s0 = start_cnt;
    start_run(2);
    repeat (2) @(negedge ACLK);
    csr_num_layers = 3'd5;
    csr_start = 1'b1;
    @(negedge ACLK);
    csr_start = 1'b0;
    wait_idle(200, "busy_start_idle");
    @(negedge ACLK);
    $display("[TB] reset/busy-start seq: starts=%0d idx=%0d cc=%0d", start_cnt - s0, layer_idx, cycle_count);
    chk("bs_starts", start_cnt - s0, 2);
    chk("bs_idx", layer_idx, 1);
    chk("bs_cc", cycle_count, 15);
    chk("bs_done", done_sticky, 1);
    chk("bs_err", err_sticky, 0);

`ifdef SEQ_WATCHDOG_EN
    resp_en = 1'b0;
    pulse_clr();
    s0 = start_cnt;
    start_run(1);
    wait_idle(100, "wd_idle");
    @(negedge ACLK);
    $display("[TB] watchdog seq: code=%0d cc=%0d", status[15:12], cycle_count);
    chk("wd_code", status[15:12], 4);
    chk("wd_err", err_sticky, 1);
    chk("wd_cc", cycle_count, 17);
    chk("wd_starts", start_cnt - s0, 1);
    resp_en = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cnn_layer_sequencer.md
Name: cnn_layer_sequencer

Overview:
- Control sequencer between the AXI4-Lite CSR register bank and the ternary CNN datapath.
- Turns a CSR start command into an ordered series of per-layer start/done handshakes, one per network layer.
- Tracks progress and errors, and reports them through status, cycle-count and interrupt outputs that the CSR bank exposes for read-back.

Parameters:
- LAYER_W, 3, width of layer count/index (max 2^LAYER_W-1 layers).
- CNT_W, 32, width of run cycle counter.
- TIMEOUT_CYC, 65536, per-layer watchdog limit in cycles (used only with optional feature).

Ports:
- ACLK  in  1  system clock, all logic rising-edge.
- ARESET  in  1  asynchronous, active-high reset.
- csr_start  in  1  one-cycle pulse, CSR write of ctrl[0]=1.
- csr_abort  in  1  one-cycle pulse, CSR write of ctrl[1]=1.
- csr_irq_en  in  1  level, interrupt enable.
- csr_irq_clr  in  1  one-cycle pulse, W1C of status done/err bits.
- csr_num_layers  in  LAYER_W  number of layers to run; sampled at start.
- layer_start  out  1  one-cycle pulse to datapath.
- layer_idx  out  LAYER_W  current layer index, stable while busy.
- layer_done  in  1  one-cycle pulse from datapath, layer finished.
- layer_err  in  1  qualified with layer_done, layer failed.
- busy  out  1  sequencer running.
- done_sticky  out  1  set on successful completion, cleared by csr_irq_clr or new start.
- err_sticky  out  1  set on error/abort/timeout, cleared likewise.
- irq  out  1  registered: csr_irq_en & (done_sticky | err_sticky).
- status  out  32  {16'b0, err_code[3:0], 1'b0, layer_idx padded to 8, busy, err_sticky, done_sticky}; low three bits at [2:0].
- cycle_count  out  CNT_W  cycles spent in the last/current run.

Behaviour:
- Reset values: all outputs 0, FSM=IDLE, num_layers_q=0, err_code=0.
- FSM states: IDLE, LAUNCH, WAIT, NEXT, FINISH.
- IDLE:
  - On csr_start with csr_num_layers!=0: latch num_layers_q, clear stickies, err_code and cycle_count, set layer_idx=0, go to LAUNCH.
  - On csr_start with csr_num_layers==0: set err_sticky, err_code=1, stay IDLE.
- LAUNCH: assert layer_start for exactly one cycle, go to WAIT.
- WAIT:
  - On layer_done & ~layer_err: go to NEXT.
  - On layer_done & layer_err: err_sticky=1, err_code=2, go to IDLE.
- NEXT:
  - If layer_idx==num_layers_q-1, go to FINISH.
  - Else layer_idx+1, go to LAUNCH. This gives a 2-cycle gap between a layer_done and the next layer_start.
- FINISH: done_sticky=1, go to IDLE; layer_idx holds the final value.
- busy=1 in LAUNCH/WAIT/NEXT/FINISH.
- cycle_count increments every cycle while busy and saturates at all-ones (no wrap); it holds after the run.
- csr_abort in any busy state: go to IDLE next cycle, err_sticky=1, err_code=3, no further layer_start. csr_abort in IDLE is ignored.
- csr_start while busy: ignored, no state change.
- Simultaneous csr_abort and layer_done in WAIT: abort wins.
- csr_irq_clr coincident with a setting event: the set wins.
- layer_done outside WAIT: ignored.
- irq is a registered output, one cycle behind the sticky bits; it drops the cycle after csr_irq_clr (or immediately after csr_irq_en goes low).
- ARESET mid-run: returns asynchronously to reset values, layer_start deasserts immediately.

Optional Feature:
- Macro SEQ_WATCHDOG_EN.
- Defined: a per-layer counter is cleared in LAUNCH and counts in WAIT. Reaching TIMEOUT_CYC-1 without layer_done sets err_sticky=1, err_code=4 and returns to IDLE.
- Undefined: no counter; WAIT waits indefinitely; err_code 4 is never produced.

Decomposition:
- Shared package cnn_ctrl_pkg holds:
  - the FSM state enum;
  - err_code constants ERR_NONE=0, ERR_ZERO_LAYERS=1, ERR_LAYER=2, ERR_ABORT=3, ERR_TIMEOUT=4;
  - status bit-position constants;
  - the default LAYER_W.
- One natural sub-module: sat_counter (parametric width, clear/enable, saturating). It is used for cycle_count and the watchdog.

Test Plan:
- num_layers=3, datapath answers each layer_start with layer_done 5 cycles later -> layer_idx 0,1,2; 3 layer_start pulses; done_sticky=1; irq=1 (irq_en=1); cycle_count=22.
- num_layers=0, csr_start -> busy stays 0; err_sticky=1; status[7:4]... err_code=1 readable at status[15:12]=1.
- num_layers=4, layer_err with layer_done on layer 1 -> IDLE; err_code=2; layer_idx=1; only 2 layer_start pulses.
- csr_abort and layer_done in the same WAIT cycle -> err_code=3; no further layer_start; csr_irq_clr then clears irq 1 cycle later.
- ARESET asserted mid-WAIT, then deasserted, then csr_start while busy in a new run -> outputs 0 during reset; the second start during the run is ignored (layer_start count unchanged).
- With SEQ_WATCHDOG_EN and TIMEOUT_CYC=16, no layer_done -> err_code=4 after 16 WAIT cycles.
